// File: rtl/bus_arb_n.sv
// ---------------------------------------------------------------------------
// bus_arb_n
//
// N-port Wishbone-style bus arbiter. Several masters share one slave. One
// master is granted at a time, and it keeps the grant until the slave acks.
// Arbitration is either fixed priority (port 0 highest) or round-robin.
// The winner's request (we/adr/dat) is latched at grant time, so the slave
// sees a stable request even if masters change their outputs during the
// cycle.
//
// Ports
//   wb_clk  - system clock, rising edge
//   wb_rst  - synchronous active-high reset
//   m_cyc   - [N]          per-master cycle request
//   m_we    - [N]          per-master write enable
//   m_adr   - [N*ADDR_W]   packed addresses, port i at [i*ADDR_W +: ADDR_W]
//   m_dat   - [N*DATA_W]   packed write data
//   m_ack   - [N]          per-master ack (one-hot or zero)
//   m_rdt   - [DATA_W]     shared read data, valid with m_ack
//   x_cyc   - slave cycle request
//   x_we    - slave write enable
//   x_adr   - [ADDR_W] slave address
//   x_dat   - [DATA_W] slave write data
//   x_ack   - slave ack
//   x_rdt   - [DATA_W] slave read data
//   busy    - grant currently held
//   grant   - [$clog2(N)] index of current or last granted port
// ---------------------------------------------------------------------------
module bus_arb_n #(
    parameter int N           = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 0
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [N-1:0]          m_cyc,
    input  logic [N-1:0]          m_we,
    input  logic [N*ADDR_W-1:0]   m_adr,
    input  logic [N*DATA_W-1:0]   m_dat,
    output logic [N-1:0]          m_ack,
    output logic [DATA_W-1:0]     m_rdt,
    output logic                  x_cyc,
    output logic                  x_we,
    output logic [ADDR_W-1:0]     x_adr,
    output logic [DATA_W-1:0]     x_dat,
    input  logic                  x_ack,
    input  logic [DATA_W-1:0]     x_rdt,
    output logic                  busy,
    output logic [$clog2(N)-1:0]  grant
);

    localparam int GW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q,  last_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   adr_q,   adr_d;
    logic [DATA_W-1:0]   dat_q,   dat_d;
    logic                aband_q, aband_d;

    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [GW-1:0]       cand;

    // Winner selection. Both loops run from the lowest-preference candidate
    // to the highest, so the last hit is the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (ROUND_ROBIN != 0) begin
            // Search order: last+1, last+2, ... wrapping, ending at last.
            for (int k = N; k >= 1; k--) begin
                cand = GW'((int'(last_q) + k) % N);
                if (m_cyc[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (m_cyc[i]) begin
                    win_found = 1'b1;
                    win_idx   = GW'(i);
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        aband_d = aband_q;
        case (state_q)
            IDLE: begin
                aband_d = 1'b0;
                if (win_found) begin
                    state_d = OWN;
                    grant_d = win_idx;
                    last_d  = win_idx;
                    we_d    = m_we[win_idx];
                    adr_d   = m_adr[int'(win_idx)*ADDR_W +: ADDR_W];
                    dat_d   = m_dat[int'(win_idx)*DATA_W +: DATA_W];
                end
            end
            OWN: begin
                // The slave cannot abort. Remember that the owner left so
                // the eventual ack is swallowed instead of reaching a master
                // that is no longer waiting.
                if (!m_cyc[grant_q]) begin
                    aband_d = 1'b1;
                end
                if (x_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            aband_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            aband_q <= aband_d;
        end
    end

    // Outputs. The ack is routed combinationally, so it is gated with the
    // owner's live m_cyc as well. This covers an owner that drops m_cyc in
    // the same cycle the slave acks.
    always_comb begin
        m_ack = '0;
        if (state_q == OWN && x_ack && m_cyc[grant_q] && !aband_q) begin
            m_ack[grant_q] = 1'b1;
        end
    end

    assign m_rdt = x_rdt;
    assign x_cyc = (state_q == OWN);
    assign busy  = (state_q == OWN);
    assign x_we  = we_q;
    assign x_adr = adr_q;
    assign x_dat = dat_q;
    assign grant = grant_q;

endmodule

// File: doc/bus_arb_n.md
# bus_arb_n

N-port Wishbone-style bus arbiter that generalises the two-port instruction-bus arbiter. It sits between several masters (CPU iBus, the dbus→ibus read bridge, future DMA or debug ports) and a single slave such as the SPI flash controller. It grants one master at a time, holds the grant until the slave acks, and supports fixed-priority or round-robin arbitration plus write cycles.

## Interface
Parameters:
- N, 2: number of master ports (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- ROUND_ROBIN, 0: 0 = fixed priority (port 0 highest); 1 = round-robin.

Ports (clock and reset first):
- wb_clk  in  1  system clock; all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- m_cyc  in  N  per-master cycle request.
- m_we  in  N  per-master write enable.
- m_adr  in  N*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W].
- m_dat  in  N*DATA_W  packed write data.
- m_ack  out  N  per-master ack, one-hot or zero.
- m_rdt  out  DATA_W  read data shared by all masters; valid when the matching m_ack bit is high.
- x_cyc  out  1  cycle request to the slave.
- x_we  out  1  write enable to the slave.
- x_adr  out  ADDR_W  address to the slave.
- x_dat  out  DATA_W  write data to the slave.
- x_ack  in  1  slave ack.
- x_rdt  in  DATA_W  slave read data.
- busy  out  1  high while a grant is held.
- grant  out  $clog2(N)  index of the current or last granted port.

## Operation
- Two states: IDLE and OWN.
- IDLE:
  - If any m_cyc is high, pick a winner, register grant, and latch m_we, m_adr and m_dat of the winner into x_we, x_adr and x_dat.
  - Go to OWN on the same edge.
- Winner selection, fixed priority (ROUND_ROBIN=0): lowest-index requesting port wins.
- Winner selection, round-robin (ROUND_ROBIN=1):
  - Search starts at (last_grant+1) mod N and wraps through N-1 back to 0.
  - last_grant updates on every grant.
- OWN:
  - x_cyc=1; x_we, x_adr and x_dat are held from the latch and do not track master changes.
  - m_ack[grant] = x_ack (combinational); all other m_ack bits stay 0.
  - m_rdt = x_rdt (combinational pass-through).
  - On x_ack, return to IDLE.
- Abandon: if the granted master drops m_cyc before x_ack, x_cyc stays high until x_ack. That ack is suppressed (m_ack stays 0), because the slave cannot abort a transaction mid-flight.
- busy = (state == OWN).
- Reset values: state IDLE, x_cyc 0, x_we 0, x_adr 0, x_dat 0, m_ack 0, busy 0, grant 0, last_grant N-1 (so port 0 wins the first round-robin search).
- Reset mid-transaction: the next edge forces IDLE and x_cyc goes low. A late x_ack arriving in IDLE is ignored: no m_ack is generated.

## Timing
- Request latency: master raises m_cyc before edge k; the grant registers at edge k; x_cyc is high from edge k. That is one cycle from m_cyc visible to x_cyc.
- Ack: x_ack high in cycle j gives m_ack[grant] high in cycle j. The master must drop m_cyc at edge j+1; x_cyc drops at edge j+1.
- IDLE spans at least the cycle after edge j+1. The next grant is therefore registered no earlier than edge j+2, so a master's deasserting m_cyc is never re-granted.
- Back-to-back throughput: one transaction per (slave latency + 2) cycles.
- Simultaneous requests: resolved purely by the selection rule. Losers hold m_cyc and wait with no timeout.
- x_ack in IDLE: ignored.
- m_ack never asserts in two consecutive cycles for the same transaction.

## Test plan
- Reset: hold wb_rst 3 cycles with all m_cyc=1. Required: x_cyc=0, m_ack=0, busy=0, grant=0 throughout. First grant after release goes to port 0.
- Single read (N=2): port 1 reads adr 0x12345678; slave acks after 5 cycles with 0xffffffff. Required: x_adr=0x12345678, x_we=0, m_ack=2'b10 for exactly one cycle, m_rdt=0xffffffff.
- Fixed priority (N=4): ports 1 and 3 request together, then port 3 keeps re-requesting. Required: order 1, then 3; port 0 joining mid-transaction is granted before port 3's re-request.
- Round-robin (N=4, ROUND_ROBIN=1): all ports request continuously for 8 transactions. Required: grant sequence 0,1,2,3,0,1,2,3, with at least 1 IDLE cycle between grants.
- Write: port 0 writes 0x12341234 to 0x40000000 while port 1 changes m_adr during OWN. Required: x_we=1, x_dat=0x12341234, and x_adr stays 0x40000000 for the whole transaction.
- Abandon and reset mid-op:
  - Port 0 drops m_cyc before ack. Required: x_cyc stays high until x_ack, and m_ack stays 0.
  - Assert wb_rst during OWN. Required: x_cyc=0 on the next edge, and a subsequent stray x_ack produces no m_ack.
